max7219_rx: RTL and testbench

Receive-side model of the LED-array SPI link: decodes the 3-wire load/data/clk stream driven onto `jd[3:1]` by the LED controller into 16-bit MAX7219 command frames. It holds the resulting digit and control register image. It is synthesizable and oversamples the SPI pins with the system clock, so it works both in the top-level bench (checking LED controller output) and on hardware as a loopback monitor.

---
 rtl/max7219_rx.sv | 143 ++++++++++++++
 tb/tb_max7219_rx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/max7219_rx.sv
// max7219_rx
//   Receive side of the 3-wire MAX7219 LED link. Oversamples spi clk/load/data
//   with i_clk, reassembles 16-bit command frames and keeps the resulting
//   digit/control register image of the display driver.
//
// Ports
//   i_clk, i_rst      system clock, synchronous active-high reset
//   i_spi_clk         SPI clock (jd[1]), asynchronous
//   i_spi_load        load/CS   (jd[2]), low while shifting, rise latches
//   i_spi_data        serial data (jd[3]), MSB first
//   o_stb             1-cycle pulse: 16-bit frame accepted
//   o_err             1-cycle pulse: frame closed with bit count != 16
//   o_addr, o_data    address/data of the last accepted frame
//   o_rows            digit registers, row n (address n+1) at [8n+7:8n]
//   o_decode, o_intensity, o_scan_limit, o_shutdown, o_test
//                     control registers 0x9, 0xA, 0xB, 0xC (inverted), 0xF
module max7219_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_spi_clk,
    input  logic        i_spi_load,
    input  logic        i_spi_data,
    output logic        o_stb,
    output logic [3:0]  o_addr,
    output logic [7:0]  o_data,
    output logic        o_err,
    output logic [63:0] o_rows,
    output logic [7:0]  o_decode,
    output logic [3:0]  o_intensity,
    output logic [2:0]  o_scan_limit,
    output logic        o_shutdown,
    output logic        o_test
);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] clk_sync, load_sync, data_sync;
    logic                   clk_d1, clk_d2, load_d1, load_d2, data_d1;
    logic                   clk_rise, load_rise, load_fall;

    state_t                 state;
    logic [4:0]             bit_cnt;
    // Only frame bits [11:0] are ever used; after 16 shifts the low 12 bits of
    // a left-shifting register hold exactly those, so the top nibble is dropped.
    logic [11:0]            sr;
    logic [7:0][7:0]        rows_q;

    // Synchronizers plus one extra stage for edge detection. Data gets the
    // same depth as clk so the bit sampled on a clk rise is the one that was
    // on the pin when the pin edge happened. The load chain resets low so a
    // load held low across reset release does not look like a falling edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            clk_sync  <= '0;
            load_sync <= '0;
            data_sync <= '0;
            clk_d1    <= 1'b0;
            clk_d2    <= 1'b0;
            load_d1   <= 1'b0;
            load_d2   <= 1'b0;
            data_d1   <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0],  i_spi_clk};
            load_sync <= {load_sync[SYNC_STAGES-2:0], i_spi_load};
            data_sync <= {data_sync[SYNC_STAGES-2:0], i_spi_data};
            clk_d1    <= clk_sync[SYNC_STAGES-1];
            clk_d2    <= clk_d1;
            load_d1   <= load_sync[SYNC_STAGES-1];
            load_d2   <= load_d1;
            data_d1   <= data_sync[SYNC_STAGES-1];
        end
    end

    assign clk_rise  =  clk_d1  & ~clk_d2;
    assign load_rise =  load_d1 & ~load_d2;
    assign load_fall = ~load_d1 &  load_d2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            sr           <= '0;
            o_stb        <= 1'b0;
            o_err        <= 1'b0;
            o_addr       <= '0;
            o_data       <= '0;
            rows_q       <= '0;
            o_decode     <= '0;
            o_intensity  <= '0;
            o_scan_limit <= '0;
            o_shutdown   <= 1'b1;
            o_test       <= 1'b0;
        end else begin
            o_stb <= 1'b0;
            o_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_fall) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        sr      <= '0;
                    end
                end
                SHIFT: begin
                    // Load rise wins over a coincident clk rise: that bit is dropped.
                    if (load_rise) begin
                        state <= IDLE;
                        if (bit_cnt == 5'd16) begin
                            o_stb  <= 1'b1;
                            o_addr <= sr[11:8];
                            o_data <= sr[7:0];
                            case (sr[11:8])
                                4'h9:    o_decode     <= sr[7:0];
                                4'hA:    o_intensity  <= sr[3:0];
                                4'hB:    o_scan_limit <= sr[2:0];
                                4'hC:    o_shutdown   <= ~sr[0];
                                4'hF:    o_test       <= sr[0];
                                default: begin
                                    // 0x1-0x8 are rows; 0x0, 0xD, 0xE write nothing.
                                    if (sr[11:8] >= 4'h1 && sr[11:8] <= 4'h8)
                                        rows_q[3'(sr[11:8] - 4'h1)] <= sr[7:0];
                                end
                            endcase
                        end else begin
                            o_err <= 1'b1;
                        end
                    end else if (clk_rise) begin
                        sr <= {sr[10:0], data_d1};
                        // Saturate at 17 so any overlong frame still reads as != 16.
                        if (bit_cnt != 5'd17)
                            bit_cnt <= bit_cnt + 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_rows = rows_q;

endmodule

// File: tb/tb_max7219_rx.sv
module tb_max7219_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_clk = 1'b0;
    logic        spi_load = 1'b1;
    logic        spi_data = 1'b0;
    logic        stb, err, shutdown, test;
    logic [3:0]  addr, intensity;
    logic [7:0]  data, decode;
    logic [63:0] rows;
    logic [2:0]  scan_limit;

    int n_cmp = 0;
    int n_err = 0;
    int stb_cnt = 0;
    int err_cnt = 0;
    int stb0, err0;

    max7219_rx #(.SYNC_STAGES(2)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_spi_clk(spi_clk), .i_spi_load(spi_load), .i_spi_data(spi_data),
        .o_stb(stb), .o_addr(addr), .o_data(data), .o_err(err),
        .o_rows(rows), .o_decode(decode), .o_intensity(intensity),
        .o_scan_limit(scan_limit), .o_shutdown(shutdown), .o_test(test)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (stb) stb_cnt++;
        if (err) err_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame_open();
        spi_load = 1'b0;
        tick(5);
    endtask

    task automatic send_bits(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            spi_data = val[i];
            tick(5);
            spi_clk = 1'b1;
            tick(5);
            spi_clk = 1'b0;
        end
    endtask

    task automatic frame_close();
        tick(5);
        spi_load = 1'b1;
        tick(8);
    endtask

    task automatic send_frame(input logic [31:0] val, input int n);
        frame_open();
        send_bits(val, n);
        frame_close();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(4);
        n_cmp++; if (stb !== 1'b0)        begin n_err++; $display("FAIL reset_stb got %b want 0", stb); end
        n_cmp++; if (err !== 1'b0)        begin n_err++; $display("FAIL reset_err got %b want 0", err); end
        n_cmp++; if (addr !== 4'h0)       begin n_err++; $display("FAIL reset_addr got %h want 0", addr); end
        n_cmp++; if (data !== 8'h00)      begin n_err++; $display("FAIL reset_data got %h want 00", data); end
        n_cmp++; if (rows !== 64'h0)      begin n_err++; $display("FAIL reset_rows got %h want 0", rows); end
        n_cmp++; if (decode !== 8'h00)    begin n_err++; $display("FAIL reset_decode got %h want 00", decode); end
        n_cmp++; if (intensity !== 4'h0)  begin n_err++; $display("FAIL reset_intensity got %h want 0", intensity); end
        n_cmp++; if (scan_limit !== 3'h0) begin n_err++; $display("FAIL reset_scan got %h want 0", scan_limit); end
        n_cmp++; if (shutdown !== 1'b1)   begin n_err++; $display("FAIL reset_shutdown got %b want 1", shutdown); end
        n_cmp++; if (test !== 1'b0)       begin n_err++; $display("FAIL reset_test got %b want 0", test); end
        rst = 1'b0;
        tick(6);
        n_cmp++; if (stb_cnt !== 0 || err_cnt !== 0)
            begin n_err++; $display("FAIL reset_no_pulse got stb=%0d err=%0d want 0/0", stb_cnt, err_cnt); end
    endtask

    // Frame 0x0C01 with cycle-exact pulse latency: load pin rises, stb high
    // after the 4th following clk edge (2 sync + 1 edge flop + 1 output reg).
    task automatic test_shutdown();
        stb0 = stb_cnt; err0 = err_cnt;
        frame_open();
        send_bits(32'h0C01, 16);
        tick(5);
        spi_load = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick(1);
            n_cmp++; if (stb !== (e == 4))
                begin n_err++; $display("FAIL shut_stb_edge%0d got %b want %b", e, stb, (e == 4)); end
            if (e == 3) begin
                n_cmp++; if (shutdown !== 1'b1) begin n_err++; $display("FAIL shut_early got %b want 1", shutdown); end
            end
            if (e == 4) begin
                n_cmp++; if (shutdown !== 1'b0) begin n_err++; $display("FAIL shut_update got %b want 0", shutdown); end
            end
        end
        tick(4);
        n_cmp++; if (addr !== 4'hC)  begin n_err++; $display("FAIL shut_addr got %h want c", addr); end
        n_cmp++; if (data !== 8'h01) begin n_err++; $display("FAIL shut_data got %h want 01", data); end
        n_cmp++; if (rows !== 64'h0 || decode !== 8'h0 || intensity !== 4'h0 || scan_limit !== 3'h0 || test !== 1'b0)
            begin n_err++; $display("FAIL shut_others got rows=%h dec=%h int=%h scan=%h test=%b want all 0", rows, decode, intensity, scan_limit, test); end
        n_cmp++; if (stb_cnt - stb0 !== 1 || err_cnt - err0 !== 0)
            begin n_err++; $display("FAIL shut_pulses got stb=%0d err=%0d want 1/0", stb_cnt - stb0, err_cnt - err0); end
    endtask

    task automatic test_regs();
        stb0 = stb_cnt; err0 = err_cnt;
        send_frame(32'h0155, 16);
        send_frame(32'h08AA, 16);
        send_frame(32'h0A0F, 16);
        send_frame(32'h0000, 16);   // no-op
        send_frame(32'h0D12, 16);   // ignored address
        send_frame(32'hF933, 16);   // top nibble don't-care -> decode
        n_cmp++; if (rows !== 64'hAA00_0000_0000_0055)
            begin n_err++; $display("FAIL regs_rows got %h want aa00000000000055", rows); end
        n_cmp++; if (intensity !== 4'hF) begin n_err++; $display("FAIL regs_intensity got %h want f", intensity); end
        n_cmp++; if (decode !== 8'h33)   begin n_err++; $display("FAIL regs_decode got %h want 33", decode); end
        n_cmp++; if (addr !== 4'h9 || data !== 8'h33)
            begin n_err++; $display("FAIL regs_addr_data got %h/%h want 9/33", addr, data); end
        n_cmp++; if (scan_limit !== 3'h0 || shutdown !== 1'b0 || test !== 1'b0)
            begin n_err++; $display("FAIL regs_untouched got scan=%h shut=%b test=%b want 0/0/0", scan_limit, shutdown, test); end
        n_cmp++; if (stb_cnt - stb0 !== 6 || err_cnt - err0 !== 0)
            begin n_err++; $display("FAIL regs_pulses got stb=%0d err=%0d want 6/0", stb_cnt - stb0, err_cnt - err0); end
    endtask

    task automatic test_errors();
        stb0 = stb_cnt; err0 = err_cnt;
        send_frame(32'h0177, 15);
        send_frame(32'h1_0B05, 17);
        frame_open();               // zero-bit frame
        frame_close();
        n_cmp++; if (err_cnt - err0 !== 3 || stb_cnt - stb0 !== 0)
            begin n_err++; $display("FAIL err_pulses got err=%0d stb=%0d want 3/0", err_cnt - err0, stb_cnt - stb0); end
        n_cmp++; if (addr !== 4'h9 || data !== 8'h33)
            begin n_err++; $display("FAIL err_hold got %h/%h want 9/33", addr, data); end
        n_cmp++; if (rows !== 64'hAA00_0000_0000_0055 || scan_limit !== 3'h0 || intensity !== 4'hF)
            begin n_err++; $display("FAIL err_regs got rows=%h scan=%h int=%h", rows, scan_limit, intensity); end
    endtask

    task automatic test_idle_clk();
        stb0 = stb_cnt; err0 = err_cnt;
        for (int i = 0; i < 4; i++) begin
            spi_data = i[0];
            spi_clk = 1'b1; tick(5);
            spi_clk = 1'b0; tick(5);
        end
        send_frame(32'h0B07, 16);
        n_cmp++; if (scan_limit !== 3'h7) begin n_err++; $display("FAIL idle_scan got %h want 7", scan_limit); end
        n_cmp++; if (addr !== 4'hB || data !== 8'h07)
            begin n_err++; $display("FAIL idle_addr_data got %h/%h want b/07", addr, data); end
        n_cmp++; if (stb_cnt - stb0 !== 1 || err_cnt - err0 !== 0)
            begin n_err++; $display("FAIL idle_pulses got stb=%0d err=%0d want 1/0", stb_cnt - stb0, err_cnt - err0); end
    endtask

    task automatic test_abort_reset();
        frame_open();
        send_bits(32'h0F, 8);
        rst = 1'b1;
        tick(3);
        n_cmp++; if (rows !== 64'h0 || decode !== 8'h0 || intensity !== 4'h0 || scan_limit !== 3'h0 || addr !== 4'h0 || data !== 8'h0)
            begin n_err++; $display("FAIL abort_regs got rows=%h dec=%h int=%h scan=%h a=%h d=%h want 0", rows, decode, intensity, scan_limit, addr, data); end
        n_cmp++; if (shutdown !== 1'b1 || test !== 1'b0)
            begin n_err++; $display("FAIL abort_ctrl got shut=%b test=%b want 1/0", shutdown, test); end
        rst = 1'b0;
        stb0 = stb_cnt; err0 = err_cnt;
        tick(2);
        send_bits(32'h01, 8);
        frame_close();
        n_cmp++; if (stb_cnt - stb0 !== 0 || err_cnt - err0 !== 0)
            begin n_err++; $display("FAIL abort_pulses got stb=%0d err=%0d want 0/0", stb_cnt - stb0, err_cnt - err0); end
        n_cmp++; if (test !== 1'b0) begin n_err++; $display("FAIL abort_test got %b want 0", test); end
        send_frame(32'h0F01, 16);
        n_cmp++; if (test !== 1'b1) begin n_err++; $display("FAIL abort_final_test got %b want 1", test); end
        n_cmp++; if (stb_cnt - stb0 !== 1 || err_cnt - err0 !== 0)
            begin n_err++; $display("FAIL abort_final_pulses got stb=%0d err=%0d want 1/0", stb_cnt - stb0, err_cnt - err0); end
    endtask

    initial begin
        test_reset();
        test_shutdown();
        test_regs();
        test_errors();
        test_idle_clk();
        test_abort_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
